// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one multicycle fpu between N_REQ requesters.
// A grant latches the requester's funct/a/b onto the fpu inputs and holds them
// until the rising edge of fpu_finish, then the result goes back to that requester.
// Optional build macro FPU_ARB_TIMEOUT_EN adds a BUSY-cycle timeout that returns
// a qNaN with rsp_err=1; without it BUSY waits indefinitely and rsp_err is 0.
//
// state | meaning
// IDLE  | arbitrate; a grant pulses req_ready and latches operands
// ISSUE | one cycle for the fpu to see the new operands; finish edges ignored
// BUSY  | wait for a finish rising edge (or timeout when enabled)
// DONE  | one-cycle rsp_valid to the granted requester
module fpu_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [2*N_REQ-1:0]    req_funct,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [1:0]            fpu_funct,
    output logic [31:0]           fpu_a,
    output logic [31:0]           fpu_b,
    input  logic [31:0]           fpu_o,
    input  logic                  fpu_finish
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("fpu_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic              finish_q;
    logic [1:0]        funct_q, funct_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       data_q, data_d;
    logic              fin_edge;
    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic [1:0]        sel_funct;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    logic              err_q, err_d;
    logic [15:0]       tmo_q, tmo_d;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign fin_edge  = fpu_finish & ~finish_q;
    assign fpu_funct = funct_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign rsp_data  = data_q;

    // Round-robin search: first set request starting one past the last grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % N_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Mux the winning requester's operation and operands.
    always_comb begin
        sel_funct = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant_idx == IDX_W'(j)) begin
                sel_funct = req_funct[2*j +: 2];
                sel_a     = req_a[32*j +: 32];
                sel_b     = req_b[32*j +: 32];
            end
        end
    end

    // One-hot strobes; req_ready is held off while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int j = 0; j < N_REQ; j++) begin
            req_ready[j] = rst_n && (state_q == S_IDLE) && grant_vld && (grant_idx == IDX_W'(j));
            rsp_valid[j] = (state_q == S_DONE) && (rr_q == IDX_W'(j));
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        funct_d = funct_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
`ifdef FPU_ARB_TIMEOUT_EN
        err_d   = err_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    rr_d    = grant_idx;
                    funct_d = sel_funct;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef FPU_ARB_TIMEOUT_EN
                tmo_d   = TMO_LOAD;
`endif
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (fin_edge) begin
                    data_d  = fpu_o;
`ifdef FPU_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_DONE;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (tmo_q == 16'd0) begin
                    data_d  = QNAN;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= IDX_W'(N_REQ - 1);
            finish_q <= 1'b0;
            funct_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            finish_q <= fpu_finish;
            funct_q  <= funct_d;
            a_q      <= a_d;
            b_q      <= b_d;
            data_q   <= data_d;
`ifdef FPU_ARB_TIMEOUT_EN
            err_q    <= err_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: vector table for grant order / results,
// plus hand sequences for stale finish, reset mid-op and (optional) timeout.
module tb_fpu_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [7:0]    req_funct;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [3:0]    rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [1:0]    fpu_funct;
    logic [31:0]   fpu_a;
    logic [31:0]   fpu_b;
    logic [31:0]   fpu_o;
    logic          fpu_finish;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fpu_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .fpu_funct  (fpu_funct),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_o      (fpu_o),
        .fpu_finish (fpu_finish)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        int          lat;
        logic [31:0] o;
        logic [3:0]  exp_grant;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] a_of(input int i);
        return 32'h3F80_0000 + (32'(i) << 20);
    endfunction

    function automatic logic [31:0] b_of(input int i);
        return 32'h4000_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        req_valid  = 4'b0000;
        fpu_finish = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"},  rsp_data,       32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        check({tag, "_fpu_funct"}, 32'(fpu_funct), 32'h0);
        check({tag, "_fpu_a"},     fpu_a,          32'h0);
        check({tag, "_fpu_b"},     fpu_b,          32'h0);
    endtask

    // One complete op; entered and left in an IDLE cycle. Finish is raised
    // in the cycle that is 'lat' cycles after ISSUE (lat >= 2).
    task automatic do_op(input logic [3:0] mask, input int lat, input logic [31:0] o,
                         input logic [3:0] exp_grant, input string tag);
        int         g;
        int         n;
        logic [3:0] gnt;
        logic       early;
        req_valid = mask;
        settle();
        n = 0;
        while (req_ready == 4'b0000 && n < 20) begin
            tick();
            settle();
            n++;
        end
        gnt = req_ready;
        check({tag, "_grant"}, 32'(gnt), 32'(exp_grant));
        g = 0;
        for (int i = 0; i < N; i++) if (exp_grant[i]) g = i;
        tick();
        check({tag, "_issue_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_issue_a"}, fpu_a, a_of(g));
        check({tag, "_issue_b"}, fpu_b, b_of(g));
        check({tag, "_issue_funct"}, 32'(fpu_funct), 32'(g % 4));
        early = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (rsp_valid != 4'b0000 || fpu_a != a_of(g) || fpu_b != b_of(g)) early = 1'b1;
            if (k == lat) begin
                fpu_finish = 1'b1;
                fpu_o      = o;
            end
        end
        check({tag, "_busy_quiet"}, 32'(early), 32'h0);
        tick();
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_grant));
        check({tag, "_rsp_data"}, rsp_data, o);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        check({tag, "_done_a"}, fpu_a, a_of(g));
        fpu_finish = 1'b0;
        tick();
        check({tag, "_post_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_post_data"}, rsp_data, o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic early;
        int   n;

        vecs[0]  = '{1'b0, 4'b0001, 5, 32'h4040_0000, 4'b0001};
        vecs[1]  = '{1'b1, 4'b1111, 3, 32'h1111_1111, 4'b0001};
        vecs[2]  = '{1'b0, 4'b1111, 2, 32'h2222_2222, 4'b0010};
        vecs[3]  = '{1'b0, 4'b1111, 4, 32'h3333_3333, 4'b0100};
        vecs[4]  = '{1'b0, 4'b1111, 2, 32'h4444_4444, 4'b1000};
        vecs[5]  = '{1'b0, 4'b1111, 3, 32'h5555_5555, 4'b0001};
        vecs[6]  = '{1'b0, 4'b1111, 2, 32'h6666_6666, 4'b0010};
        vecs[7]  = '{1'b0, 4'b1011, 3, 32'h7777_7777, 4'b1000};
        vecs[8]  = '{1'b0, 4'b0100, 2, 32'h8888_8888, 4'b0100};
        vecs[9]  = '{1'b0, 4'b0100, 6, 32'h9999_9999, 4'b0100};
        vecs[10] = '{1'b0, 4'b0011, 2, 32'hAAAA_AAAA, 4'b0001};
        vecs[11] = '{1'b0, 4'b1010, 3, 32'hBBBB_BBBB, 4'b0010};

        for (int i = 0; i < N; i++) begin
            req_funct[2*i +: 2] = 2'(i);
            req_a[32*i +: 32]   = a_of(i);
            req_b[32*i +: 32]   = b_of(i);
        end

        // Reset state, with requests pending to show req_ready stays low.
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        fpu_finish = 1'b0;
        fpu_o      = 32'h0;
        tick();
        tick();
        check_zero_outs("reset");
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        tick();

        // Vector table: single op, round-robin, withdraw, repeated single requester.
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].rst) do_reset();
            do_op(vecs[v].valid, vecs[v].lat, vecs[v].o, vecs[v].exp_grant, $sformatf("vec%0d", v));
        end
        req_valid = 4'b0000;
        settle();

        // Stale finish: already high at grant, must drop and rise again.
        fpu_finish = 1'b1;
        tick();
        tick();
        req_valid = 4'b0001;
        settle();
        check("stale_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        early = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid != 4'b0000) early = 1'b1;
        end
        check("stale_hold", 32'(early), 32'h0);
        fpu_finish = 1'b0;
        tick();
        check("stale_low", 32'(rsp_valid), 32'h0);
        fpu_finish = 1'b1;
        fpu_o      = 32'hCAFE_0001;
        tick();
        check("stale_rsp_valid", 32'(rsp_valid), 32'h1);
        check("stale_rsp_data", rsp_data, 32'hCAFE_0001);
        fpu_finish = 1'b0;
        tick();

        // Finish rising during ISSUE is ignored.
        req_valid = 4'b0010;
        settle();
        check("issue_edge_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid  = 4'b0000;
        fpu_finish = 1'b1;
        early = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rsp_valid != 4'b0000) early = 1'b1;
        end
        check("issue_edge_hold", 32'(early), 32'h0);
        fpu_finish = 1'b0;
        tick();
        fpu_finish = 1'b1;
        fpu_o      = 32'hCAFE_0002;
        tick();
        check("issue_edge_rsp_valid", 32'(rsp_valid), 32'h2);
        check("issue_edge_rsp_data", rsp_data, 32'hCAFE_0002);
        fpu_finish = 1'b0;
        tick();

        // Reset mid-op: outputs clear at once, no response, req 0 first afterwards.
        req_valid = 4'b0001;
        settle();
        check("rst_mid_grant", 32'(req_ready), 32'h1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        settle();
        check_zero_outs("rst_mid");
        fpu_finish = 1'b1;
        fpu_o      = 32'hDEAD_BEEF;
        tick();
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'h0);
        fpu_finish = 1'b0;
        tick();
        rst_n = 1'b1;
        do_op(4'b1111, 3, 32'h1234_5678, 4'b0001, "rst_after");
        req_valid = 4'b0000;
        settle();

`ifdef FPU_ARB_TIMEOUT_EN
        // Timeout: 16 BUSY cycles without a finish edge.
        req_valid = 4'b0010;
        settle();
        check("tmo_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        n = 0;
        while (rsp_valid == 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        check("tmo_latency", 32'(n), 32'd17);
        check("tmo_rsp_valid", 32'(rsp_valid), 32'h2);
        check("tmo_rsp_data", rsp_data, 32'h7FC0_0000);
        check("tmo_rsp_err", 32'(rsp_err), 32'h1);
        tick();
        check("tmo_err_hold", 32'(rsp_err), 32'h1);
        check("tmo_post_valid", 32'(rsp_valid), 32'h0);

        // Finish edge in the terminal BUSY cycle wins over the timeout.
        req_valid = 4'b0100;
        settle();
        check("tmo_race_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (rsp_valid != 4'b0000) early = 1'b1;
            if (k == 16) begin
                fpu_finish = 1'b1;
                fpu_o      = 32'hCAFE_0005;
            end
        end
        check("tmo_race_quiet", 32'(early), 32'h0);
        tick();
        check("tmo_race_valid", 32'(rsp_valid), 32'h4);
        check("tmo_race_data", rsp_data, 32'hCAFE_0005);
        check("tmo_race_err", 32'(rsp_err), 32'h0);
        fpu_finish = 1'b0;
        tick();
        do_op(4'b1000, 3, 32'h0BAD_F00D, 4'b1000, "tmo_next");
        req_valid = 4'b0000;
        settle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
